// File: rtl/aes_ht_seq.sv
// Iterative AES-128 encryption core: one round per clock, round key expanded on the fly.
// Sequential golden reference for the unrolled aes_ht_* chain (same {key, state} packing).
//   state | meaning
//   IDLE  | waiting for a block, in_ready high
//   ROUND | one AES round per cycle, round_idx 1..10
//   DONE  | ciphertext on o, held until out_ready
module aes_ht_seq #(
  parameter int ROUNDS   = 10,
  parameter bit BYTE_REV = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] g_input,
  input  logic [127:0] e_input,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] o,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic [3:0]   round_idx
);

  if (ROUNDS != 10) begin : g_rounds_check
    $error("aes_ht_seq: only ROUNDS=10 is supported");
  end

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF inverse (x^254 via a short addition chain) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x3, x7, x15, t, inv;
    x3  = gf_mul(gf_mul(x, x), x);
    x7  = gf_mul(gf_mul(x3, x3), x);
    x15 = gf_mul(gf_mul(x7, x7), x);
    t   = gf_mul(x15, x15);
    t   = gf_mul(t, t);
    t   = gf_mul(t, t);
    inv = gf_mul(gf_mul(t, x7), gf_mul(t, x7));
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] byte_rev(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = v[127-8*i -: 8];
    return r;
  endfunction

  // FIPS byte i sits at [127-8i -: 8]; byte i is row i%4, column i/4
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127-8*(row+4*c) -: 8] = sbox(s[127-8*(row+4*((c+row)%4)) -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t         fsm;
  logic [255:0] work;
  logic [127:0] key_in, pt_in, key_next, sr_out, state_next;

  assign key_in     = BYTE_REV ? byte_rev(g_input) : g_input;
  assign pt_in      = BYTE_REV ? byte_rev(e_input) : e_input;
  assign key_next   = key_expand(work[255:128], rcon(round_idx));
  assign sr_out     = sub_shift(work[127:0]);
  assign state_next = ((round_idx == LAST_ROUND) ? sr_out : mix_columns(sr_out)) ^ key_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm       <= IDLE;
      work      <= '0;
      o         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      round_idx <= '0;
      in_ready  <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            work      <= {key_in, pt_in ^ key_in};
            round_idx <= 4'd1;
            busy      <= 1'b1;
            in_ready  <= 1'b0;
            fsm       <= ROUND;
          end
        end
        ROUND: begin
          work      <= {key_next, state_next};
          round_idx <= round_idx + 4'd1;
          if (round_idx == LAST_ROUND) begin
            o         <= BYTE_REV ? byte_rev(state_next) : state_next;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            fsm       <= DONE;
          end
        end
        DONE: begin
          // in_ready stays low here so accept and emit never coincide
          if (out_ready) begin
            out_valid <= 1'b0;
            round_idx <= '0;
            in_ready  <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_ht_seq.sv
// Self-checking bench for aes_ht_seq: a byte-array AES model plus a per-cycle timing model,
// with a byte-reversed instance and a FIPS-order instance driven from the same inputs.
module tb_aes_ht_seq;
  logic         clk, rst, in_valid, out_ready;
  logic [127:0] g_input, e_input;
  logic         in_ready_r, out_valid_r, busy_r;
  logic [3:0]   round_idx_r;
  logic [127:0] o_r;
  logic         in_ready_f, out_valid_f, busy_f;
  logic [3:0]   round_idx_f;
  logic [127:0] o_f;

  aes_ht_seq #(.ROUNDS(10), .BYTE_REV(1)) dut_r (
    .clk(clk), .rst(rst), .g_input(g_input), .e_input(e_input), .in_valid(in_valid),
    .in_ready(in_ready_r), .o(o_r), .out_valid(out_valid_r), .out_ready(out_ready),
    .busy(busy_r), .round_idx(round_idx_r));

  aes_ht_seq #(.ROUNDS(10), .BYTE_REV(0)) dut_f (
    .clk(clk), .rst(rst), .g_input(g_input), .e_input(e_input), .in_valid(in_valid),
    .in_ready(in_ready_f), .o(o_f), .out_valid(out_valid_f), .out_ready(out_ready),
    .busy(busy_f), .round_idx(round_idx_f));

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] V2_KEY = 128'he4dc18adf3d05ec9e4dcc41acb990007;
  localparam logic [127:0] V2_PT  = 128'h4072da1240f930f7d3c8cf8b9322042e;
  localparam logic [127:0] V2_CT  = 128'hd225406f484809186cb5d86be4098445;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb [256];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // S-box built from the generator 3 and its inverse, independent of any field inversion
  task automatic gen_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [127:0] rev(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = v[127-8*i -: 8];
    return r;
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [1:0] b);
    logic [7:0] a2;
    a2 = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    return (b[0] ? a : 8'h00) ^ (b[1] ? a2 : 8'h00);
  endfunction

  // Textbook AES-128 on byte arrays, full key schedule up front; FIPS byte order in and out
  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   w [176];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   tmp [4];
    logic [1:0]   c [4];
    logic [7:0]   rc, acc;
    logic [127:0] res;
    c[0] = 2'd2; c[1] = 2'd3; c[2] = 2'd1; c[3] = 2'd1;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      w[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ w[i];
    end
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
      if (i % 16 == 0) begin
        tmp[0] = sb[w[i-3]] ^ rc;
        tmp[1] = sb[w[i-2]];
        tmp[2] = sb[w[i-1]];
        tmp[3] = sb[w[i-4]];
        rc = mul(rc, 2'd2);
      end
      for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
    end
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
      for (int col = 0; col < 4; col++)
        for (int row = 0; row < 4; row++) begin
          acc = 8'h00;
          if (r == 10) acc = t[row+4*col];
          else for (int k = 0; k < 4; k++) acc = acc ^ mul(t[k+4*col], c[(k-row+4)%4]);
          s[row+4*col] = acc ^ w[16*r + row + 4*col];
        end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Timing model: accept -> 10 round edges -> result shown until out_ready
  logic         m_rdy = 0, m_busy = 0, m_ov = 0;
  logic [3:0]   m_ridx = 0;
  int           m_left = 0;
  logic [127:0] m_o_r = '0, m_o_f = '0, m_pend_r = '0, m_pend_f = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rdy = 0; m_busy = 0; m_ov = 0; m_ridx = 0; m_left = 0; m_o_r = '0; m_o_f = '0;
    end else if (m_ov) begin
      if (out_ready) begin
        m_ov = 0; m_ridx = 0; m_rdy = 1;
      end
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      m_ridx = m_ridx + 4'd1;
      if (m_left == 0) begin
        m_ov = 1; m_busy = 0; m_o_r = m_pend_r; m_o_f = m_pend_f;
      end
    end else if (m_rdy && in_valid) begin
      m_pend_f = aes_ref(g_input, e_input);
      m_pend_r = rev(aes_ref(rev(g_input), rev(e_input)));
      m_left = 10; m_ridx = 4'd1; m_busy = 1; m_rdy = 0;
    end else begin
      m_rdy = 1;
    end
  end

  int           cyc = 0;
  logic         prev_ov = 0;
  int           ov_t[$];
  logic [127:0] ov_o[$];

  always @(negedge clk) begin
    cyc++;
    chk("in_ready", in_ready_r, m_rdy);
    chk("busy", busy_r, m_busy);
    chk("out_valid", out_valid_r, m_ov);
    chk("o_rev", o_r, m_o_r);
    chk("in_ready_f", in_ready_f, m_rdy);
    chk("busy_f", busy_f, m_busy);
    chk("out_valid_f", out_valid_f, m_ov);
    chk("o_fips", o_f, m_o_f);
    if (!m_ov) begin
      chk("round_idx", round_idx_r, m_ridx);
      chk("round_idx_f", round_idx_f, m_ridx);
    end
    if (out_valid_r && !prev_ov) begin
      ov_t.push_back(cyc);
      ov_o.push_back(o_r);
    end
    prev_ov = out_valid_r;
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready_r && n < 40) begin @(negedge clk); n++; end
    chk("wait_ready_bound", in_ready_r, 1'b1);
  endtask

  task automatic wait_ov();
    int n = 0;
    while (!out_valid_r && n < 40) begin @(negedge clk); n++; end
    chk("wait_out_valid_bound", out_valid_r, 1'b1);
  endtask

  task automatic wait_round(input logic [3:0] r);
    int n = 0;
    while (round_idx_r != r && n < 40) begin @(negedge clk); n++; end
    chk("wait_round_bound", round_idx_r, r);
  endtask

  task automatic send(input logic [127:0] g, input logic [127:0] e);
    wait_ready();
    g_input = g; e_input = e; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] cap, a_g, a_e, bg [3], be [3];
    int edges, n, seen;
    gen_sbox();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; g_input = '0; e_input = '0;
    #1 rst = 1'b0;
    #11;
    chk("rst_in_ready", in_ready_r, 1'b0);
    chk("rst_out_valid", out_valid_r, 1'b0);
    chk("rst_o", o_r, 128'h0);
    chk("rst_round_idx", round_idx_r, 4'd0);
    @(negedge clk) rst = 1'b1;

    chk("model_c1", aes_ref(C1_KEY, C1_PT), C1_CT);
    chk("model_v2", aes_ref(V2_KEY, V2_PT), V2_CT);

    // C.1 with latency measured in rising edges, accept edge included
    wait_ready();
    g_input = C1_KEY; e_input = C1_PT; in_valid = 1'b1;
    @(posedge clk); edges = 1;
    #1 in_valid = 1'b0;
    while (!out_valid_r && edges < 40) begin @(posedge clk); edges++; #1; end
    chk("latency_edges", edges, 11);
    chk("c1_fips_ct", o_f, C1_CT);
    @(posedge clk); #1;
    chk("out_valid_one_cycle", out_valid_r, 1'b0);
    @(negedge clk);

    // Byte-reversed port vector
    send(rev(V2_KEY), rev(V2_PT));
    wait_ov();
    chk("v2_rev_ct", o_r, rev(V2_CT));
    @(negedge clk);

    // Backpressure: result must hold for 20 cycles
    out_ready = 1'b0;
    a_g = {$urandom, $urandom, $urandom, $urandom};
    a_e = {$urandom, $urandom, $urandom, $urandom};
    send(a_g, a_e);
    wait_ov();
    cap = rev(aes_ref(rev(a_g), rev(a_e)));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid_r, 1'b1);
      chk("bp_o", o_r, cap);
      chk("bp_in_ready", in_ready_r, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", out_valid_r, 1'b0);
    chk("bp_release_in_ready", in_ready_r, 1'b1);

    // in_valid pulse with other data mid-block is ignored
    a_g = {$urandom, $urandom, $urandom, $urandom};
    a_e = {$urandom, $urandom, $urandom, $urandom};
    send(a_g, a_e);
    wait_round(4'd5);
    g_input = ~a_g; e_input = ~a_e; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_ov();
    chk("ignore_pulse_ct", o_r, rev(aes_ref(rev(a_g), rev(a_e))));
    seen = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (out_valid_r) seen++; end
    chk("no_second_out_valid", seen, 0);

    // Asynchronous reset mid-round, between clock edges
    send(C1_KEY, C1_PT);
    wait_round(4'd7);
    #2 rst = 1'b0;
    #1;
    chk("arst_o", o_r, 128'h0);
    chk("arst_o_f", o_f, 128'h0);
    chk("arst_out_valid", out_valid_r, 1'b0);
    chk("arst_round_idx", round_idx_r, 4'd0);
    chk("arst_busy", busy_r, 1'b0);
    @(negedge clk) rst = 1'b1;
    send(C1_KEY, C1_PT);
    wait_ov();
    chk("c1_after_reset", o_f, C1_CT);
    @(negedge clk);

    // Back-to-back with in_valid held high
    for (int k = 0; k < 3; k++) begin
      bg[k] = {$urandom, $urandom, $urandom, $urandom};
      be[k] = {$urandom, $urandom, $urandom, $urandom};
    end
    ov_t.delete(); ov_o.delete();
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      g_input = bg[k]; e_input = be[k];
      wait_ready();
      @(negedge clk);
    end
    in_valid = 1'b0;
    n = 0;
    while (ov_t.size() < 3 && n < 60) begin @(negedge clk); n++; end
    chk("b2b_count", ov_t.size(), 3);
    for (int k = 0; k < ov_o.size() && k < 3; k++)
      chk("b2b_ct", ov_o[k], rev(aes_ref(rev(bg[k]), rev(be[k]))));
    for (int k = 1; k < ov_t.size(); k++)
      chk("b2b_spacing", ov_t[k] - ov_t[k-1], 12);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
